// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational next-PC lookup for IF,
// single-entry update from EX, plus a free-running mispredict counter.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_npc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_is_jump,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_MAX >> 1;

    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
    logic [ENTRIES-1:0]  valid_q;

    logic [IDX-1:0]   if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX-1:0]   u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    // Instruction-alignment bits never take part in index or tag.
    logic unused_align;
    assign unused_align = &{1'b0, pc_if[1:0], upd_pc[1:0]};

    assign if_idx = pc_if[IDX+1:2];
    assign if_tag = pc_if[XLEN-1:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign pred_taken = if_hit && cnt_q[if_idx][CNT_BITS-1];
    assign pred_npc   = pred_taken ? target_q[if_idx] : pc_if + XLEN'(4);

    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
            valid_q        <= '0;
            mispredict_cnt <= '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_is_jump) begin
                    cnt_q[u_idx]    <= CNT_MAX;
                    target_q[u_idx] <= upd_target;
                end else if (upd_taken) begin
                    if (cnt_q[u_idx] != CNT_MAX)
                        cnt_q[u_idx] <= cnt_q[u_idx] + CNT_BITS'(1);
                    target_q[u_idx] <= upd_target;
                end else if (cnt_q[u_idx] != '0) begin
                    cnt_q[u_idx] <= cnt_q[u_idx] - CNT_BITS'(1);
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                cnt_q[u_idx]    <= upd_is_jump ? CNT_MAX : CNT_WT;
            end
            if (upd_mispredict)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RV32I pipeline. It replaces the static "always not-taken, flush on EX resolve" policy. The IF stage looks up the current PC and gets a predicted next PC in the same cycle. The EX stage writes back each resolved branch or jump. Storage is a direct-mapped table: tag, target, valid bit and an N-bit saturating counter per entry. A 32-bit mispredict counter is kept for on-board performance readout.

## Interface
Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, table depth; must be a power of two, at least 2. IDX = log2(ENTRIES).
- CNT_BITS, 2, saturating counter width; must be at least 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_if  in  XLEN  PC being fetched in IF.
- pred_taken  out  1  combinational; lookup hit and counter MSB = 1.
- pred_npc  out  XLEN  combinational; stored target if pred_taken, else pc_if + 4.
- upd_valid  in  1  EX has resolved a branch or jump this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome (jumps always 1).
- upd_is_jump  in  1  instruction is jal/jalr.
- upd_target  in  XLEN  actual target (pc_imm or alu_c & ~1).
- upd_mispredict  in  1  EX detected a wrong prediction (direction or target).
- mispredict_cnt  out  32  number of cycles with upd_valid and upd_mispredict.

## Operation
- Index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2]. pc[1:0] is ignored.
- Lookup is purely combinational from registered table state. There is no write-to-read bypass.
- Hit means valid[idx] and tag[idx] == tag(pc_if).
- Update is applied only when upd_valid = 1, at the next rising edge:
  - Hit, upd_is_jump = 1: counter is set to all-ones; target is overwritten.
  - Hit, conditional branch, taken: counter increments, saturating at 2^CNT_BITS-1; target is overwritten.
  - Hit, conditional branch, not taken: counter decrements, saturating at 0; target is unchanged.
  - Miss and taken: the entry is allocated, overwriting any previous occupant. valid=1, tag and target are written. Counter is set to all-ones for jumps, else to weakly-taken (MSB=1, other bits 0).
  - Miss and not taken: no change.
- mispredict_cnt increments when upd_valid && upd_mispredict. It wraps from 0xFFFF_FFFF to 0.
- upd_mispredict is ignored when upd_valid = 0.
- Each cycle touches at most one entry; no multi-cycle operations.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update contents. The update takes effect for the next cycle's lookup.

## Timing
- Prediction latency: 0 cycles, combinational from pc_if.
- Update latency: 1 cycle; visible at lookup in the cycle after upd_valid.
- Reset (rst=1 at an edge):
  - every valid cleared;
  - every counter set to weakly-not-taken (MSB=0, other bits 1; for CNT_BITS=1 the value is 0);
  - tags and targets cleared to 0;
  - mispredict_cnt = 0.
- While rst is held high, updates are discarded, so the outputs after reset are pred_taken = 0 and pred_npc = pc_if + 4.
- Reset asserted in the same cycle as upd_valid: reset wins and the update is lost.
- pc_if + 4 wraps modulo 2^XLEN.

## Test plan
ENTRIES=16, CNT_BITS=2.

1. **Reset:** after rst, pc_if=0x0000_0040 -> pred_taken=0, pred_npc=0x0000_0044; mispredict_cnt=0.
2. **Branch allocate and hysteresis:** upd at pc=0x100, taken, target=0x80 -> next cycle pc_if=0x100 gives pred_taken=1, pred_npc=0x80.
   - One not-taken update -> pred_taken=0 (counter 01).
   - Then taken twice -> counter 11.
   - Then one not-taken -> still pred_taken=1.
3. **Alias eviction:** entry at 0x100 allocated; taken jump at 0x140 (same index 0, different tag) -> lookup 0x100 misses (pred_npc=0x104); lookup 0x140 hits with the new target.
4. **Miss not-taken:** upd at pc=0x200, not taken, on an empty table -> lookup 0x200 still misses, pred_npc=0x204.
5. **Same-cycle collision:** lookup 0x100 during its allocating update -> pred_taken=0 that cycle, 1 the following cycle.
6. **Counter and reset priority:**
   - Three cycles with upd_valid=1, upd_mispredict=1 -> mispredict_cnt=3.
   - upd_mispredict=1 with upd_valid=0 -> unchanged.
   - rst together with an update -> counter 0 and no allocation.
